// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stage-enable sequencer for the 5-stage MIPS pipeline
module pipeline_controller #(
    parameter int CNT_W        = 16,
    parameter int FLUSH_SLOTS  = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_in,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             mem_wait,
    output logic             mem_timeout,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {RUN, FLUSH, MEM_WAIT, DRAIN, HALT} state_t;

    localparam logic [2:0] SLOT_RELOAD = 3'(FLUSH_SLOTS - 1);
    localparam logic [2:0] DRAIN_LOAD  = 3'(DRAIN_CYCLES);
    localparam logic [7:0] WAIT_LIMIT  = 8'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [2:0]         slot_q, slot_d;
    logic [2:0]         drain_q, drain_d;
    logic [7:0]         wait_q, wait_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;
    logic               mem_freeze;

    assign mem_freeze = dmem_req && !dmem_ready;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        drain_d       = drain_q;
        wait_d        = wait_q;
        mem_timeout_d = mem_timeout_q;
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b0;
        mem_wait      = 1'b0;

        case (state_q)
            RUN: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                exmem_en = 1'b1;
                if (mem_freeze) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    exmem_en = 1'b0;
                    mem_wait = 1'b1;
                    state_d  = MEM_WAIT;
                    wait_d   = 8'd1;
                end else if (branch_taken) begin
                    // A concurrent hazard stall is dropped: its instruction is squashed.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        state_d = FLUSH;
                        slot_d  = SLOT_RELOAD;
                    end
                end else if (stall_in) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (!imem_ready) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end else if (halt_req) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = DRAIN;
                    drain_d    = DRAIN_LOAD;
                end
            end
            FLUSH: begin
                if (mem_freeze) begin
                    mem_wait = 1'b1;
                    state_d  = MEM_WAIT;
                    wait_d   = 8'd1;
                end else begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    exmem_en   = 1'b1;
                    if (branch_taken) begin
                        idex_bubble = 1'b1;
                        slot_d      = SLOT_RELOAD;
                    end else if (slot_q <= 3'd1) begin
                        state_d = RUN;
                    end else begin
                        slot_d = slot_q - 3'd1;
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    exmem_en = 1'b1;
                    state_d  = RUN;
                end else begin
                    mem_wait = 1'b1;
                    if (wait_q == WAIT_LIMIT) begin
                        mem_timeout_d = 1'b1;
                        state_d       = HALT;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                // A freeze while draining holds the drain count in place.
                if (mem_freeze) begin
                    mem_wait = 1'b1;
                end else begin
                    ifid_flush = 1'b1;
                    exmem_en   = 1'b1;
                    drain_d    = drain_q - 3'd1;
                    if (drain_q <= 3'd1) begin
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        halted_d      = halted_q || (state_d == HALT);
        stall_count_d = stall_count_q;
        if (!pc_en && state_q != HALT && stall_count_q != {CNT_W{1'b1}}) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            slot_q        <= '0;
            drain_q       <= '0;
            wait_q        <= '0;
            mem_timeout_q <= 1'b0;
            halted_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            drain_q       <= drain_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_d;
            halted_q      <= halted_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign halted      = halted_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// tb/tb_pipeline_controller.sv - self-checking bench for pipeline_controller
module tb_pipeline_controller;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset, stall_in, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_wait, mem_timeout, halted;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_controller #(
        .CNT_W(CNT_W), .FLUSH_SLOTS(2), .MEM_TIMEOUT(15), .DRAIN_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .mem_wait(mem_wait),
        .mem_timeout(mem_timeout), .halted(halted), .stall_count(stall_count)
    );

    // in  = {reset, stall, branch, imem_ready, dmem_req, dmem_ready, halt}
    // out = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_wait, halted, mem_timeout}
    typedef struct {
        logic [6:0] in;
        logic [7:0] out;
        logic [3:0] cnt;
    } vec_t;

    localparam logic [6:0] IDLE = 7'b0001000;

    vec_t tbl[25];
    vec_t sb[$];

    function automatic vec_t mk(input logic [6:0] i, input logic [7:0] o, input int c);
        vec_t v;
        v.in  = i;
        v.out = o;
        v.cnt = 4'(c);
        return v;
    endfunction

    task automatic drive(input logic [6:0] i);
        {reset, stall_in, branch_taken, imem_ready, dmem_req, dmem_ready, halt_req} = i;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_wait, halted, mem_timeout};
    endfunction

    initial begin
        vec_t e;
        int waits;
        bit hit;

        tbl[0]  = mk(7'b1001000, 8'b11001000, 0);
        tbl[1]  = mk(7'b0101000, 8'b00011000, 0);
        tbl[2]  = mk(7'b0101000, 8'b00011000, 1);
        tbl[3]  = mk(IDLE,       8'b11001000, 2);
        tbl[4]  = mk(7'b0111000, 8'b11111000, 2);
        tbl[5]  = mk(7'b0101000, 8'b10101000, 2);
        tbl[6]  = mk(IDLE,       8'b11001000, 2);
        tbl[7]  = mk(7'b0001100, 8'b00000100, 2);
        tbl[8]  = mk(7'b0001100, 8'b00000100, 3);
        tbl[9]  = mk(7'b0001100, 8'b00000100, 4);
        tbl[10] = mk(7'b0001100, 8'b00000100, 5);
        tbl[11] = mk(7'b0001110, 8'b11001000, 6);
        tbl[12] = mk(IDLE,       8'b11001000, 6);
        tbl[13] = mk(7'b0000000, 8'b01101000, 6);
        tbl[14] = mk(7'b0011100, 8'b00000100, 7);
        tbl[15] = mk(7'b0001110, 8'b11001000, 8);
        tbl[16] = mk(7'b0001001, 8'b01101000, 8);
        tbl[17] = mk(IDLE,       8'b00101000, 9);
        tbl[18] = mk(7'b0001100, 8'b00000100, 10);
        tbl[19] = mk(IDLE,       8'b00101000, 11);
        tbl[20] = mk(7'b0111000, 8'b00101000, 12);
        tbl[21] = mk(7'b0101000, 8'b00100010, 13);
        tbl[22] = mk(7'b0011000, 8'b00100010, 13);
        tbl[23] = mk(7'b1101000, 8'b00100010, 13);
        tbl[24] = mk(IDLE,       8'b11001000, 0);

        drive(7'b1001000);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].in);
            sb.push_back(tbl[i]);
            #5;
            e = sb.pop_front();
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(e.out));
            chk($sformatf("vec%0d_cnt", i), 32'(stall_count), 32'(e.cnt));
        end

        // Data memory stuck: 16 frozen cycles (load cycle + counter 1..15) then HALT.
        waits = 0;
        hit   = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk);
            #1 drive(7'b0001100);
            #5;
            if (halted) hit = 1'b1;
            else if (mem_wait && !pc_en && !ifid_en && !exmem_en) waits++;
        end
        chk("timeout_halt_reached", 32'(halted), 32'd1);
        chk("timeout_wait_cycles", 32'(waits), 32'd16);
        chk("timeout_flag", 32'(mem_timeout), 32'd1);
        chk("timeout_cnt_sat", 32'(stall_count), 32'd15);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 drive(7'b0101110);
            #5;
            chk("timeout_sticky", 32'({halted, mem_timeout, pc_en}), 32'b110);
        end
        @(posedge clk);
        #1 drive(7'b1001000);
        @(posedge clk);
        #1 drive(IDLE);
        #5;
        chk("reset_clears", 32'({halted, mem_timeout, pc_en, 4'(stall_count)}), 32'b0010000);

        // 2^CNT_W + 5 hazard stalls: counter pins at 15.
        for (int c = 0; c < 21; c++) begin
            @(posedge clk);
            #1 drive(7'b0101000);
            #5;
            if (c == 14) chk("sat_before", 32'(stall_count), 32'd14);
        end
        chk("sat_during", 32'(stall_count), 32'd15);
        @(posedge clk);
        #1 drive(IDLE);
        #5;
        chk("sat_after", 32'({pc_en, 4'(stall_count)}), 32'b11111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
